memory_stage: RTL and testbench
===============================

MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameter FWD_EN, default 1: when 1 the forwarding outputs are driven; when 0 they are held at 0.
REQ-002 clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 in_valid  in  1  execute-stage bundle valid.
REQ-005 in_ready  out  1  stage can accept a bundle this cycle.
REQ-006 in_pc, in_result_alu, in_wd  in  64 each  execute_data_t fields: PC, ALU result / effective address, store data.
REQ-007 in_ctl  in  control_t  decoded op and regwrite/memwrite/memread/nop_signal/branch flags.
REQ-008 in_wa  in  5  destination register.
REQ-009 dreq_valid  out  1  data-bus request valid.
REQ-010 dreq_addr  out  64  request address.
REQ-011 dreq_size  out  3  request size; value 3 = 8 bytes.
REQ-012 dreq_strobe  out  8  byte write strobes.
REQ-013 dreq_data  out  64  write data.
REQ-014 dresp_data_ok  in  1  request complete.
REQ-015 dresp_data  in  64  load data.
REQ-016 out_valid  out  1  memory_data_t bundle valid.
REQ-017 out_ready  in  1  writeback accepts the bundle.
REQ-018 out_pc, out_ctl, out_result_alu, out_wd, out_wa, out_addr_31  out  memory_data_t fields.
REQ-019 out_misalign  out  1  LD/SD address not 8-byte aligned.
REQ-020 fwd_result  out  64  forwarding result.
REQ-021 fwd_wa  out  5  forwarding destination register.
REQ-022 fwd_regwrite  out  1  forwarding write enable.

Function
REQ-023 The FSM SHALL have three states:
- IDLE: no bundle held.
- WAIT: bus request outstanding.
- HOLD: result held for writeback.
REQ-024 in_ready SHALL equal (state==IDLE) || (state==HOLD && out_ready).
REQ-025 On accept (in_valid && in_ready), the stage SHALL register all input fields.
- Op is LD or SD with in_result_alu[2:0]==0: go to WAIT.
- Otherwise: go to HOLD.
REQ-026 In WAIT, the bus request SHALL be driven as follows:
- dreq_valid=1.
- dreq_addr = registered result_alu.
- dreq_size = 3.
- dreq_strobe = 8'hFF for SD, 8'h00 for LD.
- dreq_data = registered wd.
- All request fields held stable until the cycle dresp_data_ok=1.
REQ-027 On dresp_data_ok in WAIT, the stage SHALL go to HOLD.
- LD: out_result_alu is replaced by dresp_data.
- SD: out_result_alu is unchanged.
- dreq_valid SHALL drop in the following cycle.
REQ-028 out_valid SHALL be 1 exactly in HOLD; all out_* fields SHALL be stable while out_valid && !out_ready.
REQ-029 On out_valid && out_ready, the stage SHALL go to IDLE, or capture a new bundle the same cycle if in_valid.
- Back-to-back ALU ops then flow at one per cycle with 1-cycle latency.
REQ-030 Latency SHALL be as follows:
- Non-memory op: out_valid one cycle after accept.
- Memory op: out_valid the cycle after dresp_data_ok.
REQ-031 out_addr_31 SHALL equal bit 31 of the registered result_alu, i.e. the address, not the load data.
REQ-032 A misaligned LD/SD SHALL issue no bus request, go directly to HOLD with out_misalign=1, and force out_ctl.regwrite=0.
REQ-033 A bundle with ctl.nop_signal=1 SHALL pass through as a non-memory op even if memread/memwrite are set.
REQ-034 Forwarding SHALL be combinational from stage state.
- In HOLD: fwd_result = out_result_alu, fwd_wa = out_wa, fwd_regwrite = out_ctl.regwrite.
- In WAIT: fwd_regwrite=0, since load data is not yet available.
- In IDLE: fwd_regwrite=0.
REQ-035 dresp_data_ok SHALL be ignored outside WAIT.

Reset
REQ-036 While reset=0, the stage SHALL be asynchronously cleared:
- state=IDLE.
- out_valid=0, dreq_valid=0, dreq_strobe=0, out_misalign=0.
- All data registers = 0.
- fwd_* = 0.
REQ-037 Reset asserted during WAIT SHALL drop dreq_valid immediately and discard the outstanding request.
- A dresp_data_ok arriving after reset release SHALL be ignored per REQ-035.
REQ-038 After reset release, the first bundle SHALL be accepted on the first clock edge with in_valid=1.

Verification
REQ-039 ALU op (ADD, result 0x1234, wa=5, regwrite=1) with out_ready=1 -> next cycle out_valid=1, out_result_alu=0x1234, fwd_wa=5, fwd_regwrite=1.
REQ-040 LD at address 0x80001008, dresp_data_ok after 3 cycles with data 0xDEADBEEF -> dreq_valid held 3 cycles with addr 0x80001008, strobe 0x00; then out_result_alu=0xDEADBEEF, out_addr_31=1.
REQ-041 SD at address 0x100, wd=0xAA55, with out_ready=0 for 2 cycles after completion -> strobe=0xFF, data=0xAA55; out_* stable for those 2 cycles; in_ready=0.
REQ-042 LD at address 0x104 -> no dreq_valid; out_misalign=1 and out_ctl.regwrite=0 next cycle.
REQ-043 Reset asserted during WAIT, then dresp_data_ok pulsed after release -> dreq_valid=0 asynchronously; no out_valid is generated.
REQ-044 Four back-to-back ALU ops with out_ready=1 -> four consecutive cycles of out_valid=1, with in_ready=1 throughout.

Source files
------------

// File: rtl/memory_stage.sv
// Memory stage: takes one execute bundle at a time, issues an 8-byte data-bus
// request for aligned loads/stores, and holds the result for writeback.
// Misaligned LD/SD bypass the bus and are flagged; nop bundles pass straight through.

package memory_stage_pkg;
  typedef enum logic [3:0] {
    OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL,
    OP_LD, OP_SD, OP_BEQ, OP_BNE, OP_JAL
  } op_t;

  typedef struct packed {
    op_t  op;
    logic regwrite;
    logic memwrite;
    logic memread;
    logic nop_signal;
    logic branch;
  } control_t;
endpackage

// state  | meaning
// S_IDLE | no bundle held
// S_WAIT | bus request outstanding
// S_HOLD | result held for writeback
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter bit FWD_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_pc,
  input  logic [63:0] in_result_alu,
  input  logic [63:0] in_wd,
  input  control_t    in_ctl,
  input  logic [4:0]  in_wa,
  output logic        dreq_valid,
  output logic [63:0] dreq_addr,
  output logic [2:0]  dreq_size,
  output logic [7:0]  dreq_strobe,
  output logic [63:0] dreq_data,
  input  logic        dresp_data_ok,
  input  logic [63:0] dresp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output control_t    out_ctl,
  output logic [63:0] out_result_alu,
  output logic [63:0] out_wd,
  output logic [4:0]  out_wa,
  output logic        out_addr_31,
  output logic        out_misalign,
  output logic [63:0] fwd_result,
  output logic [4:0]  fwd_wa,
  output logic        fwd_regwrite
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

  state_t      state;
  logic [63:0] pc_q, res_q, wd_q;
  control_t    ctl_q;
  logic [4:0]  wa_q;
  logic        a31_q, mis_q;

  logic        accept, in_mem, in_aligned, fwd_on;
  control_t    in_ctl_mod;

  // Accept decision and classification of the incoming bundle
  always_comb begin
    in_ready   = (state == S_IDLE) || ((state == S_HOLD) && out_ready);
    accept     = in_valid && in_ready;
    in_mem     = ((in_ctl.op == OP_LD) || (in_ctl.op == OP_SD)) && !in_ctl.nop_signal;
    in_aligned = (in_result_alu[2:0] == 3'b000);
    in_ctl_mod = in_ctl;
    if (in_mem && !in_aligned) in_ctl_mod.regwrite = 1'b0;
  end

  // Stage FSM with registered valid/strobe outputs; a new accept overrides HOLD->IDLE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      out_valid   <= 1'b0;
      dreq_valid  <= 1'b0;
      dreq_strobe <= 8'h00;
      pc_q        <= '0;
      res_q       <= '0;
      wd_q        <= '0;
      ctl_q       <= '0;
      wa_q        <= '0;
      a31_q       <= 1'b0;
      mis_q       <= 1'b0;
    end else begin
      case (state)
        S_WAIT: begin
          if (dresp_data_ok) begin
            if (ctl_q.op == OP_LD) res_q <= dresp_data;
            state       <= S_HOLD;
            dreq_valid  <= 1'b0;
            dreq_strobe <= 8'h00;
            out_valid   <= 1'b1;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase

      if (accept) begin
        pc_q  <= in_pc;
        res_q <= in_result_alu;
        wd_q  <= in_wd;
        ctl_q <= in_ctl_mod;
        wa_q  <= in_wa;
        a31_q <= in_result_alu[31];
        mis_q <= in_mem && !in_aligned;
        if (in_mem && in_aligned) begin
          state       <= S_WAIT;
          dreq_valid  <= 1'b1;
          dreq_strobe <= (in_ctl.op == OP_SD) ? 8'hFF : 8'h00;
          out_valid   <= 1'b0;
        end else begin
          state       <= S_HOLD;
          dreq_valid  <= 1'b0;
          dreq_strobe <= 8'h00;
          out_valid   <= 1'b1;
        end
      end
    end
  end

  // Bus request and writeback bundle come straight from the held registers
  always_comb begin
    dreq_addr      = res_q;
    dreq_data      = wd_q;
    dreq_size      = dreq_valid ? 3'd3 : 3'd0;
    out_pc         = pc_q;
    out_ctl        = ctl_q;
    out_result_alu = res_q;
    out_wd         = wd_q;
    out_wa         = wa_q;
    out_addr_31    = a31_q;
    out_misalign   = mis_q;
  end

  // Forwarding only exposes a result once it is final (HOLD)
  always_comb begin
    fwd_on       = FWD_EN && (state == S_HOLD);
    fwd_result   = fwd_on ? res_q : 64'd0;
    fwd_wa       = fwd_on ? wa_q : 5'd0;
    fwd_regwrite = fwd_on && ctl_q.regwrite;
  end

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: occupancy-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_memory_stage;
  import memory_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_pc = '0, in_result_alu = '0, in_wd = '0;
  control_t    in_ctl = '0;
  logic [4:0]  in_wa = '0;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_data_ok = 1'b0;
  logic [63:0] dresp_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_pc;
  control_t    out_ctl;
  logic [63:0] out_result_alu, out_wd;
  logic [4:0]  out_wa;
  logic        out_addr_31, out_misalign;
  logic [63:0] fwd_result;
  logic [4:0]  fwd_wa;
  logic        fwd_regwrite;

  int n_cmp = 0;
  int n_bad = 0;

  memory_stage #(.FWD_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_result_alu(in_result_alu), .in_wd(in_wd), .in_ctl(in_ctl), .in_wa(in_wa),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_ctl(out_ctl),
    .out_result_alu(out_result_alu), .out_wd(out_wd), .out_wa(out_wa),
    .out_addr_31(out_addr_31), .out_misalign(out_misalign),
    .fwd_result(fwd_result), .fwd_wa(fwd_wa), .fwd_regwrite(fwd_regwrite)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: one slot that is either empty, awaiting the bus, or holding a result
  typedef struct {
    logic [63:0] pc, res, wd;
    control_t    ctl;
    logic [4:0]  wa;
    logic        a31, mis, is_ld, is_sd;
  } ent_t;

  ent_t m_e;
  bit   m_full = 0;
  bit   m_bus  = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_full = 0;
      m_bus  = 0;
    end else begin
      bit rdy;
      bit mem;
      rdy = !m_full || (!m_bus && out_ready);
      if (m_full && m_bus) begin
        if (dresp_data_ok) begin
          if (m_e.is_ld) m_e.res = dresp_data;
          m_bus = 0;
        end
      end else if (m_full && out_ready) begin
        m_full = 0;
      end
      if (in_valid && rdy) begin
        mem        = (in_ctl.op == OP_LD || in_ctl.op == OP_SD) && !in_ctl.nop_signal;
        m_e.pc     = in_pc;
        m_e.res    = in_result_alu;
        m_e.wd     = in_wd;
        m_e.wa     = in_wa;
        m_e.a31    = in_result_alu[31];
        m_e.is_ld  = mem && in_ctl.op == OP_LD;
        m_e.is_sd  = mem && in_ctl.op == OP_SD;
        m_e.mis    = mem && (in_result_alu % 8 != 0);
        m_e.ctl    = in_ctl;
        if (m_e.mis) m_e.ctl.regwrite = 1'b0;
        m_bus      = mem && !m_e.mis;
        m_full     = 1;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    bit hold;
    hold = m_full && !m_bus;
    check("ck_in_ready", 64'(in_ready), 64'(!m_full || (hold && out_ready)));
    check("ck_out_valid", 64'(out_valid), 64'(hold));
    check("ck_dreq_valid", 64'(dreq_valid), 64'(m_full && m_bus));
    if (m_full && m_bus) begin
      check("ck_dreq_addr", dreq_addr, m_e.res);
      check("ck_dreq_size", 64'(dreq_size), 64'd3);
      check("ck_dreq_strobe", 64'(dreq_strobe), m_e.is_sd ? 64'hFF : 64'h00);
      check("ck_dreq_data", dreq_data, m_e.wd);
    end else begin
      check("ck_dreq_strobe_idle", 64'(dreq_strobe), 64'h00);
    end
    if (hold) begin
      check("ck_out_pc", out_pc, m_e.pc);
      check("ck_out_ctl", 64'(out_ctl), 64'(m_e.ctl));
      check("ck_out_result", out_result_alu, m_e.res);
      check("ck_out_wd", out_wd, m_e.wd);
      check("ck_out_wa", 64'(out_wa), 64'(m_e.wa));
      check("ck_out_addr_31", 64'(out_addr_31), 64'(m_e.a31));
      check("ck_out_misalign", 64'(out_misalign), 64'(m_e.mis));
      check("ck_fwd_result", fwd_result, m_e.res);
      check("ck_fwd_wa", 64'(fwd_wa), 64'(m_e.wa));
      check("ck_fwd_regwrite", 64'(fwd_regwrite), 64'(m_e.ctl.regwrite));
    end else begin
      check("ck_fwd_regwrite_off", 64'(fwd_regwrite), 64'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input op_t op, input logic rw, input logic mw,
                       input logic mr, input logic nop, input logic [63:0] pc,
                       input logic [63:0] res, input logic [63:0] wd, input logic [4:0] wa);
    in_valid           = v;
    in_ctl             = '0;
    in_ctl.op          = op;
    in_ctl.regwrite    = rw;
    in_ctl.memwrite    = mw;
    in_ctl.memread     = mr;
    in_ctl.nop_signal  = nop;
    in_pc              = pc;
    in_result_alu      = res;
    in_wd              = wd;
    in_wa              = wa;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int dv_cycles;
    // Reset state
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_dreq_valid", 64'(dreq_valid), 64'd0);
    check("rst_dreq_strobe", 64'(dreq_strobe), 64'd0);
    check("rst_out_misalign", 64'(out_misalign), 64'd0);
    check("rst_out_result", out_result_alu, 64'd0);
    check("rst_fwd_result", fwd_result, 64'd0);
    check("rst_fwd_regwrite", 64'(fwd_regwrite), 64'd0);
    @(negedge clk); #1;
    reset = 1'b1;

    // ALU op, one-cycle latency, forwarding
    drive(1, OP_ADD, 1, 0, 0, 0, 64'h1000, 64'h1234, 64'h0, 5'd5);
    step();
    check("alu_out_valid", 64'(out_valid), 64'd1);
    check("alu_result", out_result_alu, 64'h1234);
    check("alu_fwd_wa", 64'(fwd_wa), 64'd5);
    check("alu_fwd_regwrite", 64'(fwd_regwrite), 64'd1);
    in_valid = 0;
    step();
    check("alu_drain", 64'(out_valid), 64'd0);

    // Aligned load, response after three request cycles
    drive(1, OP_LD, 1, 0, 1, 0, 64'h1004, 64'h8000_1008, 64'h0, 5'd7);
    step();
    in_valid = 0;
    dv_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      if (dreq_valid && dreq_addr == 64'h8000_1008 && dreq_strobe == 8'h00) dv_cycles++;
      check("ld_fwd_wait", 64'(fwd_regwrite), 64'd0);
      if (i == 2) begin
        dresp_data_ok = 1;
        dresp_data    = 64'hDEAD_BEEF;
      end
      step();
    end
    dresp_data_ok = 0;
    check("ld_dreq_cycles", 64'(dv_cycles), 64'd3);
    check("ld_dreq_drop", 64'(dreq_valid), 64'd0);
    check("ld_out_valid", 64'(out_valid), 64'd1);
    check("ld_result", out_result_alu, 64'hDEAD_BEEF);
    check("ld_addr_31", 64'(out_addr_31), 64'd1);
    check("ld_fwd_result", fwd_result, 64'hDEAD_BEEF);
    step();
    check("ld_drain", 64'(out_valid), 64'd0);

    // Store with writeback backpressure
    out_ready = 0;
    drive(1, OP_SD, 0, 1, 0, 0, 64'h1008, 64'h100, 64'hAA55, 5'd0);
    step();
    in_valid = 0;
    check("sd_strobe", 64'(dreq_strobe), 64'hFF);
    check("sd_data", dreq_data, 64'hAA55);
    dresp_data_ok = 1;
    dresp_data    = 64'h9999;
    step();
    dresp_data_ok = 0;
    drive(1, OP_ADD, 1, 0, 0, 0, 64'h100C, 64'h77, 64'h0, 5'd3);
    for (int i = 0; i < 2; i++) begin
      #1;
      check("sd_hold_valid", 64'(out_valid), 64'd1);
      check("sd_hold_result", out_result_alu, 64'h100);
      check("sd_hold_wd", out_wd, 64'hAA55);
      check("sd_hold_pc", out_pc, 64'h1008);
      check("sd_in_ready", 64'(in_ready), 64'd0);
      step();
    end
    out_ready = 1;
    #1;
    check("sd_release_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 0;
    check("sd_next_valid", 64'(out_valid), 64'd1);
    check("sd_next_result", out_result_alu, 64'h77);
    step();

    // Misaligned load
    drive(1, OP_LD, 1, 0, 1, 0, 64'h1010, 64'h104, 64'h0, 5'd9);
    step();
    in_valid = 0;
    check("mis_dreq", 64'(dreq_valid), 64'd0);
    check("mis_valid", 64'(out_valid), 64'd1);
    check("mis_flag", 64'(out_misalign), 64'd1);
    check("mis_regwrite", 64'(out_ctl.regwrite), 64'd0);
    step();

    // nop bundle carrying memread passes through
    drive(1, OP_LD, 0, 0, 1, 1, 64'h1014, 64'h40, 64'h0, 5'd2);
    step();
    in_valid = 0;
    check("nop_dreq", 64'(dreq_valid), 64'd0);
    check("nop_valid", 64'(out_valid), 64'd1);
    check("nop_result", out_result_alu, 64'h40);
    step();

    // Four back-to-back ALU ops
    for (int i = 0; i < 4; i++) begin
      drive(1, OP_ADD, 1, 0, 0, 0, 64'h2000 + 64'(4 * i), 64'h500 + 64'(i), 64'h0, 5'(10 + i));
      #1;
      check("b2b_in_ready", 64'(in_ready), 64'd1);
      step();
      check("b2b_valid", 64'(out_valid), 64'd1);
      check("b2b_result", out_result_alu, 64'h500 + 64'(i));
    end
    in_valid = 0;
    step();

    // Reset during WAIT, late response ignored
    drive(1, OP_LD, 1, 0, 1, 0, 64'h3000, 64'h2000, 64'h0, 5'd4);
    step();
    in_valid = 0;
    check("rw_wait", 64'(dreq_valid), 64'd1);
    #2;
    reset = 0;
    #1;
    check("rw_dreq_drop", 64'(dreq_valid), 64'd0);
    check("rw_out_valid", 64'(out_valid), 64'd0);
    check("rw_strobe", 64'(dreq_strobe), 64'd0);
    @(negedge clk); #1;
    reset = 1;
    dresp_data_ok = 1;
    dresp_data    = 64'h5555;
    step();
    dresp_data_ok = 0;
    check("rw_late_ok_valid", 64'(out_valid), 64'd0);
    check("rw_late_ok_dreq", 64'(dreq_valid), 64'd0);
    step();
    check("rw_still_idle", 64'(out_valid), 64'd0);

    // First bundle after reset accepted at once
    drive(1, OP_SUB, 1, 0, 0, 0, 64'h4000, 64'hABC, 64'h0, 5'd1);
    step();
    in_valid = 0;
    check("post_rst_valid", 64'(out_valid), 64'd1);
    check("post_rst_result", out_result_alu, 64'hABC);
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
